// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor3_dbnc_if.sv
// Signal bundle for the NOR3 ZN debounce stage.
// master: the logic that drives the raw ZN level and control and consumes the
// qualified outputs. slave: the debounce block itself.
interface gf180mcu_fd_sc_mcu9t5v0__nor3_dbnc_if;
  logic i;       // raw NOR3 ZN, may be asynchronous
  logic en;      // qualification enable
  logic clr;     // sticky clear
  logic q;       // debounced level
  logic rise;    // one-cycle strobe on q 0->1
  logic fall;    // one-cycle strobe on q 1->0
  logic sticky;  // latched "q has risen"

  modport master (output i, en, clr, input q, rise, fall, sticky);
  modport slave  (input i, en, clr, output q, rise, fall, sticky);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor3_dbnc.sv
// Registered debounce stage for a NOR3 ZN output.
// Two-flop synchroniser, then a stability counter: q only follows the
// synchronised level after DEPTH consecutive cycles of disagreement.
// Optional sticky "has risen" flag built when NOR3_DBNC_STICKY_EN is defined;
// otherwise sticky is tied low and clr is ignored.
// All outputs are flop outputs; reset is synchronous, active-low.
module gf180mcu_fd_sc_mcu9t5v0__nor3_dbnc #(
  parameter int DEPTH = 4  // legal 1..255
) (
  input logic clk,
  input logic rn,
  gf180mcu_fd_sc_mcu9t5v0__nor3_dbnc_if.slave bus
);

  localparam logic [7:0] LAST = 8'(DEPTH - 1);

  logic [1:0] sync_pipe;  // [0] = s1, [1] = s2
  logic       s2;
  logic [7:0] cnt;
  logic       q_r;
  logic       rise_r;
  logic       fall_r;
  logic       upd;        // this edge commits a new q value

  assign s2  = sync_pipe[1];
  assign upd = bus.en && (s2 != q_r) && (cnt == LAST);

  // Synchroniser runs every edge, independent of en.
  always_ff @(posedge clk) begin
    if (!rn) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], bus.i};
  end

  // Stability counter and qualified level; strobes last exactly one cycle.
  // cnt is capped at LAST, so it can never wrap.
  always_ff @(posedge clk) begin
    if (!rn) begin
      cnt    <= '0;
      q_r    <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      if (bus.en) begin
        if (s2 == q_r) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          q_r    <= s2;
          cnt    <= '0;
          rise_r <= s2;
          fall_r <= ~s2;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  assign bus.q    = q_r;
  assign bus.rise = rise_r;
  assign bus.fall = fall_r;

`ifdef NOR3_DBNC_STICKY_EN
  logic sticky_r;

  // Set on the edge q goes high; a coincident clr loses to the set.
  always_ff @(posedge clk) begin
    if (!rn)                sticky_r <= 1'b0;
    else if (upd && s2)     sticky_r <= 1'b1;
    else if (bus.clr)       sticky_r <= 1'b0;
  end

  assign bus.sticky = sticky_r;
`else
  logic unused_clr;
  assign unused_clr = bus.clr;
  assign bus.sticky = 1'b0;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__nor3_dbnc.sv
// Bench for the NOR3 debounce stage: one DEPTH=4 and one DEPTH=1 instance
// driven with the same stimulus. Expected outputs come from a small
// behavioural model, queued when stimulus is applied and popped after the edge.
module tb_gf180mcu_fd_sc_mcu9t5v0__nor3_dbnc;

  typedef struct packed {
    logic q;
    logic rise;
    logic fall;
    logic sticky;
  } exp_t;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__nor3_dbnc_if bus4();
  gf180mcu_fd_sc_mcu9t5v0__nor3_dbnc_if bus1();

  gf180mcu_fd_sc_mcu9t5v0__nor3_dbnc #(.DEPTH(4)) dut4 (.clk(clk), .rn(rn), .bus(bus4));
  gf180mcu_fd_sc_mcu9t5v0__nor3_dbnc #(.DEPTH(1)) dut1 (.clk(clk), .rn(rn), .bus(bus1));

  // Reference state, index 0 = DEPTH 4, index 1 = DEPTH 1.
  logic m_s1[2], m_s2[2], m_q[2], m_rise[2], m_fall[2], m_st[2];
  int   m_cnt[2];
  exp_t sb4[$];
  exp_t sb1[$];

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic i, input logic en, input logic clr);
    bus4.i = i;  bus4.en = en;  bus4.clr = clr;
    bus1.i = i;  bus1.en = en;  bus1.clr = clr;
  endtask

  // Behavioural next state for one instance, from the inputs held before the edge.
  task automatic model_edge(input int k, input int depth);
    logic rs;
    if (!rn) begin
      m_s1[k] = 0; m_s2[k] = 0; m_q[k] = 0; m_cnt[k] = 0;
      m_rise[k] = 0; m_fall[k] = 0; m_st[k] = 0;
      return;
    end
    rs = 0;
    m_rise[k] = 0;
    m_fall[k] = 0;
    if (bus4.en) begin
      if (m_s2[k] == m_q[k]) m_cnt[k] = 0;
      else if (m_cnt[k] == depth - 1) begin
        m_q[k] = m_s2[k];
        m_cnt[k] = 0;
        if (m_s2[k]) begin m_rise[k] = 1; rs = 1; end
        else m_fall[k] = 1;
      end else m_cnt[k] = m_cnt[k] + 1;
    end
`ifdef NOR3_DBNC_STICKY_EN
    if (rs) m_st[k] = 1;
    else if (bus4.clr) m_st[k] = 0;
`else
    m_st[k] = rs & 1'b0;
`endif
    m_s2[k] = m_s1[k];
    m_s1[k] = bus4.i;
  endtask

  // One clock: queue expectations, take the edge, compare away from it.
  task automatic step();
    exp_t e;
    model_edge(0, 4);
    model_edge(1, 1);
    sb4.push_back('{m_q[0], m_rise[0], m_fall[0], m_st[0]});
    sb1.push_back('{m_q[1], m_rise[1], m_fall[1], m_st[1]});
    @(posedge clk);
    #1;
    e = sb4.pop_front();
    chk("d4_q",      8'(bus4.q),      8'(e.q));
    chk("d4_rise",   8'(bus4.rise),   8'(e.rise));
    chk("d4_fall",   8'(bus4.fall),   8'(e.fall));
    chk("d4_sticky", 8'(bus4.sticky), 8'(e.sticky));
    e = sb1.pop_front();
    chk("d1_q",      8'(bus1.q),      8'(e.q));
    chk("d1_rise",   8'(bus1.rise),   8'(e.rise));
    chk("d1_fall",   8'(bus1.fall),   8'(e.fall));
    chk("d1_sticky", 8'(bus1.sticky), 8'(e.sticky));
    chk("d4_excl",   8'(bus4.rise & bus4.fall), 8'd0);
    chk("d1_excl",   8'(bus1.rise & bus1.fall), 8'd0);
  endtask

  task automatic steps(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  initial begin
    int rise_edge;
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 0; m_s2[k] = 0; m_q[k] = 0; m_cnt[k] = 0;
      m_rise[k] = 0; m_fall[k] = 0; m_st[k] = 0;
    end
    drive(1'b1, 1'b1, 1'b0);
    @(negedge clk);

    // Reset held 3 edges with i=1, en=1: everything stays 0.
    rn = 1'b0;
    steps(3);
    chk("rst_q",  8'(bus4.q),  8'd0);
    chk("rst_cnt", dut4.cnt,   8'd0);

    // Release: q must rise on edge 5 counted from the first rn=1 edge.
    rn = 1'b1;
    rise_edge = -1;
    for (int j = 0; j < 8; j++) begin
      step();
      if (bus4.rise && rise_edge < 0) rise_edge = j;
    end
    chk("rst_rise_edge", 8'(rise_edge), 8'd5);
    chk("step_q_hi", 8'(bus4.q), 8'd1);

    // Fall after 5 edges with a single strobe.
    drive(1'b0, 1'b1, 1'b0);
    steps(8);
    chk("step_q_lo", 8'(bus4.q), 8'd0);

    // Glitch: 3 cycles high is below DEPTH=4.
    drive(1'b1, 1'b1, 1'b0);
    steps(3);
    drive(1'b0, 1'b1, 1'b0);
    steps(8);
    chk("glitch_q",   8'(bus4.q), 8'd0);
    chk("glitch_cnt", dut4.cnt,   8'd0);

    // En freeze with q=1: two qualifying cycles, then en low for 10.
    drive(1'b1, 1'b1, 1'b0);
    steps(8);
    drive(1'b0, 1'b1, 1'b0);
    steps(4);
    drive(1'b0, 1'b0, 1'b0);
    steps(10);
    chk("freeze_q", 8'(bus4.q), 8'd1);
    drive(1'b0, 1'b1, 1'b0);
    step();
    chk("thaw_q1", 8'(bus4.q), 8'd1);
    step();
    chk("thaw_q2", 8'(bus4.q), 8'd0);
    steps(3);

    // DEPTH=1 follower: toggle every 3 cycles.
    for (int t = 0; t < 6; t++) begin
      drive(~bus4.i, 1'b1, 1'b0);
      steps(3);
    end
    drive(1'b0, 1'b1, 1'b0);
    steps(6);

    // Sticky: rise, clr pulse, then clr coincident with a DEPTH=4 rise.
    drive(1'b1, 1'b1, 1'b0);
    steps(7);
    drive(1'b1, 1'b1, 1'b1);
    step();
    drive(1'b1, 1'b1, 1'b0);
    steps(2);
    drive(1'b0, 1'b1, 1'b0);
    steps(7);
    drive(1'b1, 1'b1, 1'b0);
    steps(5);
    drive(1'b1, 1'b1, 1'b1);
    step();
    drive(1'b1, 1'b1, 1'b0);
    steps(3);
`ifdef NOR3_DBNC_STICKY_EN
    chk("sticky_set_wins", 8'(bus4.sticky), 8'd1);
`else
    chk("sticky_tied", 8'(bus4.sticky), 8'd0);
`endif

    // Random tail against the model.
    for (int j = 0; j < 300; j++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 9) == 0));
      step();
    end

    // Reset mid-qualification discards the partial count.
    drive(1'b1, 1'b1, 1'b0);
    steps(4);
    rn = 1'b0;
    step();
    chk("midrst_cnt", dut4.cnt, 8'd0);
    rn = 1'b1;
    steps(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
